// File: rtl/aim_match_serializer.sv
// rtl/aim_match_serializer.sv - captures a 32-lane match vector and serializes matched (lane, pos) pairs lowest lane first
module aim_match_serializer #(
    parameter int LANES  = 32,
    parameter int POS_W  = 9,
    parameter int LANE_W = 5,
    parameter int CNT_W  = 9
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    input  logic [LANES-1:0]            i_lane_valid,
    input  logic [LANES-1:0][POS_W-1:0] i_pos,
    input  logic                        i_last,
    output logic                        o_ready,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [LANE_W-1:0]           o_lane,
    output logic [POS_W-1:0]            o_pos,
    output logic                        o_last,
    output logic                        o_done,
    output logic [CNT_W-1:0]            o_count,
    output logic                        o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [LANES-1:0]            r_pending;
    logic [LANES-1:0][POS_W-1:0] r_pos_buf;
    logic                        r_last;
    logic [CNT_W-1:0]            r_count;
    logic                        r_overflow;

    logic                        w_capture;
    logic                        w_xfer;
    logic [LANES-1:0]            w_low_bit;
    logic [LANES-1:0]            w_pend_clr;
    logic                        w_one_left;
    logic [LANE_W-1:0]           w_lane;

    // Isolate the lowest set bit; clearing it yields the post-transfer mask.
    assign w_low_bit  = r_pending & (~r_pending + {{(LANES-1){1'b0}}, 1'b1});
    assign w_pend_clr = r_pending & ~w_low_bit;
    assign w_one_left = (r_pending != '0) && (w_pend_clr == '0);

    always_comb begin
        w_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lane = i[LANE_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_capture = 1'b1;
                    if (i_lane_valid != '0) begin
                        w_state_nxt = S_DRAIN;
                    end else if (i_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (i_ready) begin
                    w_xfer = 1'b1;
                    if (w_pend_clr == '0) begin
                        w_state_nxt = r_last ? S_DONE : S_IDLE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
            r_pos_buf <= '0;
            r_last    <= 1'b0;
        end else if (w_capture) begin
            r_pending <= i_lane_valid;
            r_pos_buf <= i_pos;
            r_last    <= i_last;
        end else if (w_xfer) begin
            r_pending <= w_pend_clr;
        end
    end

    // Count spans every iteration of a frame and is released only after the done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (r_state == S_DONE) begin
            r_count <= '0;
        end else if (w_xfer && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_valid && (r_state != S_IDLE)) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = (r_state == S_DRAIN);
    assign o_lane     = w_lane;
    assign o_pos      = r_pos_buf[w_lane];
    assign o_last     = o_valid & r_last & w_one_left;
    assign o_done     = (r_state == S_DONE);
    assign o_count    = (r_state == S_DONE) ? r_count : '0;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_aim_match_serializer.sv
// tb/tb_aim_match_serializer.sv - scoreboard bench for aim_match_serializer
module tb_aim_match_serializer;

    logic              clk;
    logic              rst_n;
    logic              i_valid;
    logic [31:0]       i_lane_valid;
    logic [31:0][8:0]  i_pos;
    logic              i_last;
    logic              o_ready;
    logic              o_valid;
    logic              i_ready;
    logic [4:0]        o_lane;
    logic [8:0]        o_pos;
    logic              o_last;
    logic              o_done;
    logic [8:0]        o_count;
    logic              o_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0] lane;
        logic [8:0] pos;
        logic       last;
    } pair_t;

    pair_t      exp_pairs[$];
    logic [8:0] exp_done[$];

    aim_match_serializer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .i_lane_valid (i_lane_valid),
        .i_pos        (i_pos),
        .i_last       (i_last),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_lane       (o_lane),
        .o_pos        (o_pos),
        .o_last       (o_last),
        .o_done       (o_done),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted pair and every done pulse is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (exp_pairs.size() == 0) begin
                check("unexpected_pair_lane", {27'd0, o_lane}, 32'hFFFF_FFFF);
            end else begin
                pair_t e;
                e = exp_pairs.pop_front();
                check("pair_lane", {27'd0, o_lane}, {27'd0, e.lane});
                check("pair_pos",  {23'd0, o_pos},  {23'd0, e.pos});
                check("pair_last", {31'd0, o_last}, {31'd0, e.last});
            end
        end
        if (rst_n && o_done) begin
            if (exp_done.size() == 0) begin
                check("unexpected_done_count", {23'd0, o_count}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] c;
                c = exp_done.pop_front();
                check("done_count", {23'd0, o_count}, {23'd0, c});
            end
        end
    end

    task automatic capture(input logic [31:0] mask, input logic [31:0][8:0] pos, input logic last);
        @(posedge clk); #1;
        i_valid      = 1'b1;
        i_lane_valid = mask;
        i_pos        = pos;
        i_last       = last;
        @(posedge clk); #1;
        i_valid      = 1'b0;
        i_lane_valid = '0;
        i_pos        = '0;
        i_last       = 1'b0;
    endtask

    task automatic push_pair(input int lane, input int pos, input logic last);
        pair_t p;
        p.lane = lane[4:0];
        p.pos  = pos[8:0];
        p.last = last;
        exp_pairs.push_back(p);
    endtask

    // Wait until idle with both queues drained, bounded by a cycle budget.
    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!(o_ready && exp_pairs.size() == 0 && exp_done.size() == 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain_timeout"}, {31'd0, (k >= budget)}, 32'd0);
    endtask

    logic [31:0][8:0] pv;
    logic             rpat [5];

    initial begin
        rst_n        = 1'b0;
        i_valid      = 1'b0;
        i_lane_valid = '0;
        i_pos        = '0;
        i_last       = 1'b0;
        i_ready      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    {31'd0, o_ready},    32'd1);
        check("rst_valid",    {31'd0, o_valid},    32'd0);
        check("rst_done",     {31'd0, o_done},     32'd0);
        check("rst_overflow", {31'd0, o_overflow}, 32'd0);
        check("rst_count",    {23'd0, o_count},    32'd0);
        rst_n = 1'b1;

        // Test 2: lanes {0,3,17}, full-rate drain
        pv = '0; pv[3] = 9'd40; pv[0] = 9'd33; pv[17] = 9'd63;
        i_ready = 1'b1;
        push_pair(0, 33, 1'b0); push_pair(3, 40, 1'b0); push_pair(17, 63, 1'b1);
        exp_done.push_back(9'd3);
        capture(32'h0002_0009, pv, 1'b1);
        @(negedge clk);
        check("t2_latency_valid", {31'd0, o_valid}, 32'd1);
        wait_idle("t2", 20);
        @(negedge clk);
        check("t2_count_cleared", {23'd0, o_count}, 32'd0);

        // Test 3: same capture, ready pattern 1,0,0,1,1
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        push_pair(0, 33, 1'b0); push_pair(3, 40, 1'b0); push_pair(17, 63, 1'b1);
        exp_done.push_back(9'd3);
        capture(32'h0002_0009, pv, 1'b1);
        for (int k = 0; k < 5; k++) begin
            i_ready = rpat[k];
            @(negedge clk);
            if (!rpat[k]) begin
                check("t3_hold_lane",  {27'd0, o_lane}, 32'd3);
                check("t3_hold_pos",   {23'd0, o_pos},  32'd40);
                check("t3_hold_valid", {31'd0, o_valid}, 32'd1);
            end
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        wait_idle("t3", 20);

        // Test 4: 32-lane iteration then empty last iteration
        for (int l = 0; l < 32; l++) begin
            pv[l] = l[8:0];
            push_pair(l, l, 1'b0);
        end
        capture(32'hFFFF_FFFF, pv, 1'b0);
        wait_idle("t4a", 60);
        exp_done.push_back(9'd32);
        capture(32'h0, pv, 1'b1);
        @(negedge clk);
        check("t4_done_latency", {31'd0, o_done}, 32'd1);
        wait_idle("t4b", 10);

        // Test 5: dropped capture during drain
        i_ready = 1'b0;
        pv = '0; pv[5] = 9'd100;
        capture(32'h0000_0020, pv, 1'b1);
        pv = '0; pv[1] = 9'd7;
        capture(32'h0000_0002, pv, 1'b0);
        @(negedge clk);
        check("t5_overflow", {31'd0, o_overflow}, 32'd1);
        check("t5_keep_lane", {27'd0, o_lane}, 32'd5);
        check("t5_keep_pos",  {23'd0, o_pos},  32'd100);
        push_pair(5, 100, 1'b1);
        exp_done.push_back(9'd1);
        @(posedge clk); #1;
        i_ready = 1'b1;
        wait_idle("t5", 20);
        repeat (2) @(negedge clk);
        check("t5_overflow_sticky", {31'd0, o_overflow}, 32'd1);

        // Test 6: async reset mid-drain with 10 pending
        i_ready = 1'b0;
        pv = '0;
        capture(32'h0000_03FF, pv, 1'b1);
        @(negedge clk);
        check("t6_valid_before", {31'd0, o_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async_clear", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready",    {31'd0, o_ready},    32'd1);
        check("t6_count",    {23'd0, o_count},    32'd0);
        check("t6_overflow", {31'd0, o_overflow}, 32'd0);
        check("t6_valid",    {31'd0, o_valid},    32'd0);

        check("sb_pairs_left", exp_pairs.size(), 32'd0);
        check("sb_done_left",  exp_done.size(),  32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
